// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

    localparam int SERIAL_ADDER_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder built from two half adders; the serial adder's only arithmetic cell.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha0 (.a(a),  .b(b),   .sum(s1),  .carry(c1));
    half_adder u_ha1 (.a(s1), .b(cin), .sum(sum), .carry(c2));

    assign cout = c1 | c2;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder computing a + b + cin, LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start; results held
// RUN   | one operand bit pair added per cycle
// DONE  | result presented, done high for one cycle
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADDER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int              CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] sum_next;

    full_adder u_fa (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB so the result ends up LSB-aligned after WIDTH shifts.
    always_comb begin
        sum_next            = sum >> 1;
        sum_next[WIDTH-1]   = fa_sum;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    carry <= fa_cout;
                    cnt   <= cnt + 1'b1;
                    sum   <= sum_next;
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cout  <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry register holds the carry into the MSB on the final cycle
                        ovf   <= carry ^ fa_cout;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) against an arithmetic reference model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] prev_sum;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        int unsigned t;
        t = int'(x) + int'(y) + int'(c);
        return t[W:0];
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic c);
        int s;
        s = int'($signed(x)) + int'($signed(y)) + int'(c);
        return (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
    endfunction

    task automatic drive_start(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        start = 1'b1;
        a     = x;
        b     = y;
        cin   = c;
    endtask

    // Called at a falling edge with start already driven; returns cycles until done (-1 if none).
    task automatic wait_done(input int max_cyc, input int inj_cyc, input logic [W-1:0] inj_a,
                             input int rst_cyc, output int lat, output int busy_cnt,
                             output logic [W-1:0] first_sum);
        bit seen;
        seen      = 0;
        lat       = 0;
        busy_cnt  = 0;
        first_sum = '0;
        while (lat < max_cyc && !seen) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                start     = 1'b0;
                first_sum = sum;
            end
            if (busy) busy_cnt++;
            if (done) seen = 1;
            if (lat == inj_cyc) begin
                start = 1'b1;
                a     = inj_a;
            end
            if (lat == inj_cyc + 1) start = 1'b0;
            if (lat == rst_cyc) rst_n = 1'b0;
            if (lat == rst_cyc + 1) begin
                check("rst_busy", busy, 0);
                check("rst_sum", sum, 0);
                check("rst_cout", cout, 0);
                check("rst_done", done, 0);
                rst_n = 1'b1;
            end
        end
        if (!seen) lat = -1;
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic c, input int lat, input int bc,
                                input logic [W-1:0] fs);
        logic [W:0] r;
        r = ref_add(x, y, c);
        check({tag, "_latency"}, lat, W + 1);
        check({tag, "_busy_cycles"}, bc, W);
        check({tag, "_sum_held"}, fs, prev_sum);
        check({tag, "_sum"}, sum, r[W-1:0]);
        check({tag, "_cout"}, cout, r[W]);
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, ovf, ref_ovf(x, y, c));
`endif
        prev_sum = r[W-1:0];
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_sum"}, sum, prev_sum);
    endtask

    task automatic run_case(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic c);
        int           lat;
        int           bc;
        logic [W-1:0] fs;
        @(negedge clk);
        drive_start(x, y, c);
        wait_done(4 * W, -10, '0, -10, lat, bc, fs);
        check_result(tag, x, y, c, lat, bc, fs);
        idle_check(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat;
        int           bc;
        logic [W-1:0] fs;
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        logic         rc;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        prev_sum = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sum", sum, 0);
        check("reset_cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
        check("reset_ovf", ovf, 0);
`endif
        rst_n = 1'b1;

        run_case("add_05_03", 8'h05, 8'h03, 1'b0);
        run_case("add_ff_01", 8'hFF, 8'h01, 1'b0);
        run_case("add_7f_01", 8'h7F, 8'h01, 1'b0);

        // back-to-back: next start driven in the DONE cycle
        @(negedge clk);
        drive_start(8'hFF, 8'hFF, 1'b1);
        wait_done(4 * W, -10, '0, -10, lat, bc, fs);
        check_result("b2b_first", 8'hFF, 8'hFF, 1'b1, lat, bc, fs);
        drive_start(8'h10, 8'h20, 1'b0);
        wait_done(4 * W, -10, '0, -10, lat, bc, fs);
        check_result("b2b_second", 8'h10, 8'h20, 1'b0, lat, bc, fs);
        idle_check("b2b_second");

        // start pulse during RUN is ignored
        @(negedge clk);
        drive_start(8'hAA, 8'h55, 1'b0);
        wait_done(4 * W, 3, 8'h01, -10, lat, bc, fs);
        check_result("ignore_start", 8'hAA, 8'h55, 1'b0, lat, bc, fs);
        idle_check("ignore_start");

        // reset mid-RUN aborts with no done
        @(negedge clk);
        drive_start(8'h12, 8'h34, 1'b0);
        wait_done(4 * W, -10, '0, 4, lat, bc, fs);
        check("abort_no_done", lat, -1);
        prev_sum = '0;
        run_case("after_reset", 8'h3C, 8'h4D, 1'b1);

        for (int i = 0; i < 20; i++) begin
            rx = W'($urandom);
            ry = W'($urandom);
            rc = 1'($urandom);
            run_case($sformatf("rand%0d", i), rx, ry, rc);
        end

        @(negedge clk);
        rx = W'($urandom);
        ry = W'($urandom);
        rc = 1'($urandom);
        drive_start(rx, ry, rc);
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] cx;
            logic [W-1:0] cy;
            logic         cc;
            cx = rx;
            cy = ry;
            cc = rc;
            wait_done(4 * W, -10, '0, -10, lat, bc, fs);
            check_result($sformatf("chain%0d", i), cx, cy, cc, lat, bc, fs);
            if (i < 5) begin
                rx = W'($urandom);
                ry = W'($urandom);
                rc = 1'($urandom);
                drive_start(rx, ry, rc);
            end
        end
        idle_check("chain_end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
